// File: rtl/decay_sweep_scheduler_pkg.sv
// Shared types for the per-timestep membrane decay sweep.
// Sweep FSM states and the decay rate codes understood by potential_decay.
package decay_sweep_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WB,
        ST_DONE
    } state_e;

    localparam logic [2:0] DECAY_DIV1   = 3'd0;
    localparam logic [2:0] DECAY_DIV2   = 3'd1;
    localparam logic [2:0] DECAY_DIV4   = 3'd2;
    localparam logic [2:0] DECAY_DIV8   = 3'd3;
    localparam logic [2:0] DECAY_DIV2P4 = 3'd4;

    // Undefined codes fall back to "no decay".
    function automatic logic [2:0] clamp_rate(input logic [2:0] r);
        return (r > DECAY_DIV2P4) ? DECAY_DIV1 : r;
    endfunction

endpackage

// File: rtl/decay_sweep_scheduler_rate_table.sv
// Per-neuron decay rate register file.
// One synchronous clamped write port, one combinational read port.
module decay_sweep_scheduler_rate_table
    import decay_sweep_scheduler_pkg::*;
#(
    parameter int NEURONS = 64,
    parameter int ADDR_W  = 6
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [2:0]        wr_rate_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [2:0]        rd_rate_o
);

    logic [2:0] rate_q [NEURONS];

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int i = 0; i < NEURONS; i++) begin
                rate_q[i] <= DECAY_DIV1;
            end
        end else if (we_i) begin
            rate_q[wr_addr_i] <= clamp_rate(wr_rate_i);
        end
    end

    assign rd_rate_o = rate_q[rd_addr_i];

endmodule

// File: rtl/decay_sweep_scheduler.sv
// Sweeps every neuron potential through potential_decay once per timestep,
// sharing the single-port potential memory with the spike accumulator.
module decay_sweep_scheduler
    import decay_sweep_scheduler_pkg::*;
#(
    parameter int NEURONS = 64,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              timestep,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [2:0]        cfg_rate,
    output logic [2:0]        dec_rate,
    output logic [DATA_W-1:0] dec_pot_out,
    input  logic [DATA_W-1:0] dec_pot_in,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              sweep_done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NEURONS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] pot_q, pot_d;
    logic              overrun_q, overrun_d;
    logic [2:0]        rate_rd;

    decay_sweep_scheduler_rate_table #(
        .NEURONS (NEURONS),
        .ADDR_W  (ADDR_W)
    ) u_rates (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .we_i      (cfg_we),
        .wr_addr_i (cfg_addr),
        .wr_rate_i (cfg_rate),
        .rd_addr_i (idx_q),
        .rd_rate_o (rate_rd)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pot_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pot_q     <= pot_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pot_d       = pot_q;
        overrun_d   = overrun_q | (timestep & (state_q != ST_IDLE));
        acc_gnt     = 1'b0;
        mem_addr    = '0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        dec_rate    = '0;
        dec_pot_out = '0;
        sweep_done  = 1'b0;
        // Outputs are held quiet during reset so an abandoned sweep never writes.
        if (RESET_N) begin
            acc_gnt = acc_req & ((state_q == ST_IDLE) | (state_q == ST_RD));
            if (acc_gnt) begin
                mem_addr  = acc_addr;
                mem_re    = ~acc_we;
                mem_we    = acc_we;
                mem_wdata = acc_wdata;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (timestep) begin
                        state_d = ST_RD;
                        idx_d   = '0;
                    end
                end
                ST_RD: begin
                    if (!acc_req) begin
                        mem_addr = idx_q;
                        mem_re   = 1'b1;
                        state_d  = ST_CAP;
                    end
                end
                ST_CAP: begin
                    pot_d   = mem_rdata;
                    state_d = ST_WB;
                end
                ST_WB: begin
                    dec_pot_out = pot_q;
                    dec_rate    = rate_rd;
                    mem_addr    = idx_q;
                    mem_we      = 1'b1;
                    mem_wdata   = dec_pot_in;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RD;
                    end
                end
                ST_DONE: begin
                    sweep_done = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_decay_sweep_scheduler.sv
// Directed + randomized bench for decay_sweep_scheduler (NEURONS=4).
// Owns the potential memory and the potential_decay unit as behavioural models.
module tb_decay_sweep_scheduler;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          timestep;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [2:0]    cfg_rate;
    logic [2:0]    dec_rate;
    logic [DW-1:0] dec_pot_out;
    logic [DW-1:0] dec_pot_in;
    logic          acc_req;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic          acc_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          sweep_done;
    logic          overrun;

    logic [31:0] mem [N];
    int          we_cnt   = 0;
    int          done_cnt = 0;
    int          checks   = 0;
    int          errors   = 0;

    decay_sweep_scheduler #(
        .NEURONS (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .timestep    (timestep),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_rate    (cfg_rate),
        .dec_rate    (dec_rate),
        .dec_pot_out (dec_pot_out),
        .dec_pot_in  (dec_pot_in),
        .acc_req     (acc_req),
        .acc_we      (acc_we),
        .acc_addr    (acc_addr),
        .acc_wdata   (acc_wdata),
        .acc_gnt     (acc_gnt),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .overrun     (overrun)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
        end
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (sweep_done) done_cnt <= done_cnt + 1;
    end

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        m = m * (2.0 ** e);
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real    a;
        int     e;
        longint m;
        if (r == 0.0) return 32'd0;
        a = (r < 0.0) ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = longint'((a - 1.0) * 8388608.0);
        return {(r < 0.0), 8'(e + 127), 23'(m)};
    endfunction

    function automatic logic [31:0] decay(input logic [31:0] p, input logic [2:0] r);
        real x;
        x = f2r(p);
        case (r)
            3'd1:    return r2f(x / 2.0);
            3'd2:    return r2f(x / 4.0);
            3'd3:    return r2f(x / 8.0);
            3'd4:    return r2f(x / 2.0 + x / 4.0);
            default: return p;
        endcase
    endfunction

    // Values with 17 significant bits so every decay result is exact.
    function automatic logic [31:0] rand_f();
        return {1'($urandom), 8'($urandom_range(100, 150)), 16'($urandom), 7'd0};
    endfunction

    always_comb dec_pot_in = decay(dec_pot_out, dec_rate);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rate(input int a, input logic [2:0] r);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_rate = r;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic load(input int a, input logic [31:0] v);
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = AW'(a);
        acc_wdata = v;
        #1;
        chk("acc_gnt_idle", 64'(acc_gnt), 64'(1));
        tick();
        acc_req = 1'b0;
        acc_we  = 1'b0;
    endtask

    task automatic do_sweep(output int lat);
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        lat = 1;
        while (!sweep_done && lat < 400) begin
            tick();
            lat++;
        end
        chk("sweep_done_seen", 64'(sweep_done), 64'(1));
        tick();
    endtask

    logic [31:0] v   [N];
    logic [31:0] ex  [N];
    logic [2:0]  rt  [N];
    logic [31:0] w;
    int          c;
    int          lat;
    int          w0;
    int          d0;

    initial begin
        RESET_N   = 1'b0;
        timestep  = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_rate  = '0;
        acc_req   = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(sweep_done), 64'(0));
        chk("rst_overrun", 64'(overrun), 64'(0));
        chk("rst_mem_re", 64'(mem_re), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_dec_pot", 64'(dec_pot_out), 64'(0));
        RESET_N = 1'b1;
        tick();
        chk("idle_mem_addr", 64'(mem_addr), 64'(0));
        chk("idle_dec_rate", 64'(dec_rate), 64'(0));

        // T1: all rates zero leave memory unchanged, exact timing
        v[0] = 32'h3F800000; v[1] = 32'h40000000;
        v[2] = 32'hC0800000; v[3] = 32'h41000000;
        for (int i = 0; i < N; i++) load(i, v[i]);
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k <= 12) chk("t1_busy", 64'(busy), 64'(1));
            chk("t1_done", 64'(sweep_done), 64'(k == 13));
            tick();
        end
        chk("t1_idle", 64'(busy), 64'(0));
        for (int i = 0; i < N; i++) chk("t1_mem", 64'(mem[i]), 64'(v[i]));

        // T2: one neuron per decay code
        for (int i = 0; i < N; i++) set_rate(i, 3'(i + 1));
        for (int i = 0; i < N; i++) load(i, 32'h41000000);
        do_sweep(lat);
        chk("t2_latency", 64'(lat), 64'(13));
        chk("t2_mem0", 64'(mem[0]), 64'h40800000);
        chk("t2_mem1", 64'(mem[1]), 64'h40000000);
        chk("t2_mem2", 64'(mem[2]), 64'h3F800000);
        chk("t2_mem3", 64'(mem[3]), 64'h40C00000);

        // T3: accumulator holds the port for 5 cycles in RD of neuron 2
        for (int i = 0; i < N; i++) begin
            rt[i] = 3'($urandom_range(0, 4));
            v[i]  = rand_f();
            set_rate(i, rt[i]);
            load(i, v[i]);
        end
        w = rand_f();
        for (int i = 0; i < N; i++) ex[i] = decay((i == 3) ? w : v[i], rt[i]);
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        c = 1;
        repeat (6) begin tick(); c++; end
        for (int k = 0; k < 5; k++) begin
            acc_req   = 1'b1;
            acc_we    = (k == 0);
            acc_addr  = (k == 0) ? AW'(3) : AW'(0);
            acc_wdata = w;
            #1;
            chk("t3_gnt", 64'(acc_gnt), 64'(1));
            chk("t3_mem_we", 64'(mem_we), 64'(k == 0));
            chk("t3_mem_re", 64'(mem_re), 64'(k != 0));
            tick();
            c++;
        end
        acc_req = 1'b0;
        acc_we  = 1'b0;
        #1;
        chk("t3_gnt_off", 64'(acc_gnt), 64'(0));
        while (!sweep_done && c < 400) begin tick(); c++; end
        chk("t3_latency", 64'(c), 64'(18));
        tick();
        for (int i = 0; i < N; i++) chk("t3_mem", 64'(mem[i]), 64'(ex[i]));

        // T4: second timestep mid-sweep is dropped and flagged
        chk("t4_overrun_pre", 64'(overrun), 64'(0));
        for (int i = 0; i < N; i++) begin
            rt[i] = 3'($urandom_range(1, 4));
            v[i]  = rand_f();
            ex[i] = decay(v[i], rt[i]);
            set_rate(i, rt[i]);
            load(i, v[i]);
        end
        d0 = done_cnt;
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        c = 1;
        repeat (5) begin tick(); c++; end
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        c++;
        chk("t4_overrun", 64'(overrun), 64'(1));
        while (c < 40) begin tick(); c++; end
        chk("t4_done_count", 64'(done_cnt - d0), 64'(1));
        chk("t4_overrun_sticky", 64'(overrun), 64'(1));
        for (int i = 0; i < N; i++) chk("t4_mem", 64'(mem[i]), 64'(ex[i]));

        // T5: reset during write-back of neuron 1
        for (int i = 0; i < N; i++) begin
            rt[i] = 3'($urandom_range(1, 4));
            v[i]  = rand_f();
            ex[i] = (i == 0) ? decay(v[i], rt[i]) : v[i];
            set_rate(i, rt[i]);
            load(i, v[i]);
        end
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        repeat (5) tick();
        RESET_N = 1'b0;
        #1;
        chk("t5_we_gated", 64'(mem_we), 64'(0));
        w0 = we_cnt;
        repeat (2) begin
            tick();
            chk("t5_busy", 64'(busy), 64'(0));
            chk("t5_mem_we", 64'(mem_we), 64'(0));
        end
        chk("t5_no_writes", 64'(we_cnt), 64'(w0));
        chk("t5_overrun_clr", 64'(overrun), 64'(0));
        RESET_N = 1'b1;
        tick();
        for (int i = 0; i < N; i++) chk("t5_mem", 64'(mem[i]), 64'(ex[i]));
        do_sweep(lat);
        for (int i = 0; i < N; i++) chk("t5_rates_zero", 64'(mem[i]), 64'(ex[i]));

        // T6: out-of-range code clamps; a cfg write during WB uses the old rate
        rt[3] = 3'($urandom_range(0, 4));
        set_rate(0, 3'd7);
        set_rate(1, 3'd1);
        set_rate(2, 3'd3);
        set_rate(3, rt[3]);
        for (int i = 0; i < N; i++) load(i, 32'h41000000);
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        c = 1;
        repeat (5) begin tick(); c++; end
        cfg_we   = 1'b1;
        cfg_addr = AW'(1);
        cfg_rate = 3'd2;
        #1;
        chk("t6_wb_old_rate", 64'(dec_rate), 64'(1));
        chk("t6_wb_pot", 64'(dec_pot_out), 64'h41000000);
        tick();
        c++;
        cfg_we = 1'b0;
        while (!sweep_done && c < 400) begin tick(); c++; end
        chk("t6_latency", 64'(c), 64'(13));
        tick();
        chk("t6_mem0", 64'(mem[0]), 64'h41000000);
        chk("t6_mem1", 64'(mem[1]), 64'h40800000);
        chk("t6_mem2", 64'(mem[2]), 64'h3F800000);
        chk("t6_mem3", 64'(mem[3]), 64'(decay(32'h41000000, rt[3])));
        do_sweep(lat);
        chk("t6_mem0_again", 64'(mem[0]), 64'h41000000);
        chk("t6_mem1_new_rate", 64'(mem[1]), 64'h3F800000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
